// File: rtl/bus_split_arbiter.sv
// Two-master bus arbiter with one outstanding split transaction.
// Parks a split owner, frees the bus, and resumes the parked master with split_grant.
`timescale 1ns/1ps
module bus_split_arbiter #(
  parameter int RR_EN         = 0,
  parameter int SPLIT_TIMEOUT = 255
) (
  input  logic clk,
  input  logic rstn,
  input  logic breq1,
  input  logic breq2,
  input  logic ssplit,
  input  logic sready,
  output logic bgrant1,
  output logic bgrant2,
  output logic msel,
  output logic split_grant,
  output logic split_err
);

  localparam bit            TO_EN    = (SPLIT_TIMEOUT > 0);
  localparam int            CW       = (SPLIT_TIMEOUT > 0) ? $clog2(SPLIT_TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SPLIT_TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT1 = 2'd1,
    GNT2 = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic          split_pend_q, split_pend_d;
  logic          split_mst_q, split_mst_d;
  logic          rr_last_q, rr_last_d;
  logic          msel_q, msel_d;
  logic          split_grant_q, split_grant_d;
  logic          split_err_q, split_err_d;
  logic [CW-1:0] cnt_q, cnt_d;

  logic reclaim;
  logic elig1, elig2;
  logic pick_m2;
  logic cur_m2;
  logic cur_req;

  assign reclaim = (state_q == IDLE) && split_pend_q && sready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q       <= IDLE;
      split_pend_q  <= 1'b0;
      split_mst_q   <= 1'b0;
      rr_last_q     <= 1'b1;
      msel_q        <= 1'b0;
      split_grant_q <= 1'b0;
      split_err_q   <= 1'b0;
      cnt_q         <= '0;
    end else begin
      state_q       <= state_d;
      split_pend_q  <= split_pend_d;
      split_mst_q   <= split_mst_d;
      rr_last_q     <= rr_last_d;
      msel_q        <= msel_d;
      split_grant_q <= split_grant_d;
      split_err_q   <= split_err_d;
      cnt_q         <= cnt_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    split_pend_d  = split_pend_q;
    split_mst_d   = split_mst_q;
    rr_last_d     = rr_last_q;
    msel_d        = msel_q;
    split_grant_d = split_grant_q;
    split_err_d   = 1'b0;
    cnt_d         = cnt_q;

    // The parked master may not win arbitration while its split is outstanding.
    elig1 = breq1 && !(split_pend_q && !split_mst_q);
    elig2 = breq2 && !(split_pend_q && split_mst_q);
    if (elig1 && elig2) begin
      pick_m2 = (RR_EN != 0) ? ~rr_last_q : 1'b0;
    end else begin
      pick_m2 = elig2;
    end

    cur_m2  = (state_q == GNT2);
    cur_req = cur_m2 ? breq2 : breq1;

    if (TO_EN && split_pend_q) begin
      if ((cnt_q == CNT_LAST) && !reclaim) begin
        split_pend_d = 1'b0;
        split_err_d  = 1'b1;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end

    case (state_q)
      IDLE: begin
        if (reclaim) begin
          state_d       = split_mst_q ? GNT2 : GNT1;
          split_grant_d = 1'b1;
          split_pend_d  = 1'b0;
          rr_last_d     = split_mst_q;
          msel_d        = split_mst_q;
        end else if (elig1 || elig2) begin
          state_d       = pick_m2 ? GNT2 : GNT1;
          split_grant_d = 1'b0;
          rr_last_d     = pick_m2;
          msel_d        = pick_m2;
        end
      end
      GNT1, GNT2: begin
        // A split wins over a simultaneous request drop.
        if (ssplit) begin
          state_d       = IDLE;
          split_pend_d  = 1'b1;
          split_mst_d   = cur_m2;
          split_grant_d = 1'b0;
          cnt_d         = '0;
        end else if (!cur_req) begin
          state_d       = IDLE;
          split_grant_d = 1'b0;
        end
      end
      default: begin
        state_d       = IDLE;
        split_grant_d = 1'b0;
      end
    endcase
  end

  assign bgrant1     = (state_q == GNT1);
  assign bgrant2     = (state_q == GNT2);
  assign msel        = msel_q;
  assign split_grant = split_grant_q;
  assign split_err   = split_err_q;

endmodule

// File: tb/tb_bus_split_arbiter.sv
// Scoreboard bench for bus_split_arbiter: two instances (fixed priority and round-robin)
// share stimulus; a per-instance behavioural model queues the expected outputs each cycle.
`timescale 1ns/1ps
module tb_bus_split_arbiter;

  localparam int TO0 = 8;
  localparam int TO1 = 5;

  logic clk = 1'b0;
  logic rstn;
  logic breq1, breq2, ssplit, sready;
  logic [1:0] g1, g2, ms, sg, se;

  int total = 0;
  int bad   = 0;
  int edge_cnt = 0;

  typedef struct packed {
    logic g1;
    logic g2;
    logic ms;
    logic sg;
    logic se;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];

  // Model state per instance: owner/parked are master numbers (0 = none).
  int m_owner[2];
  int m_parked[2];
  int m_ptime[2];
  int m_last[2];
  int m_sel[2];
  bit m_res[2];
  bit m_err[2];
  int p_rr[2];
  int p_to[2];

  always #5 clk = ~clk;

  bus_split_arbiter #(.RR_EN(0), .SPLIT_TIMEOUT(TO0)) dut0 (
    .clk(clk), .rstn(rstn), .breq1(breq1), .breq2(breq2), .ssplit(ssplit), .sready(sready),
    .bgrant1(g1[0]), .bgrant2(g2[0]), .msel(ms[0]), .split_grant(sg[0]), .split_err(se[0])
  );

  bus_split_arbiter #(.RR_EN(1), .SPLIT_TIMEOUT(TO1)) dut1 (
    .clk(clk), .rstn(rstn), .breq1(breq1), .breq2(breq2), .ssplit(ssplit), .sready(sready),
    .bgrant1(g1[1]), .bgrant2(g2[1]), .msel(ms[1]), .split_grant(sg[1]), .split_err(se[1])
  );

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    total++;
    if (act !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_owner[k]  = 0;
      m_parked[k] = 0;
      m_ptime[k]  = 0;
      m_last[k]   = 2;
      m_sel[k]    = 0;
      m_res[k]    = 1'b0;
      m_err[k]    = 1'b0;
    end
  endtask

  task automatic model_step(input int k);
    int own, park, w;
    bit rec, expire, e1, e2, req;
    own  = m_owner[k];
    park = m_parked[k];
    m_err[k] = 1'b0;
    rec    = (own == 0) && (park != 0) && (sready == 1'b1);
    expire = (p_to[k] != 0) && (park != 0) && ((edge_cnt - m_ptime[k]) == p_to[k]) && !rec;
    if (expire) begin
      m_parked[k] = 0;
      m_err[k]    = 1'b1;
    end
    if (own == 0) begin
      if (rec) begin
        m_owner[k]  = park;
        m_res[k]    = 1'b1;
        m_parked[k] = 0;
        m_last[k]   = park;
        m_sel[k]    = park - 1;
      end else begin
        e1 = (breq1 == 1'b1) && (park != 1);
        e2 = (breq2 == 1'b1) && (park != 2);
        w = 0;
        if (e1 && e2) w = (p_rr[k] != 0 && m_last[k] == 1) ? 2 : 1;
        else if (e1) w = 1;
        else if (e2) w = 2;
        if (w != 0) begin
          m_owner[k] = w;
          m_res[k]   = 1'b0;
          m_last[k]  = w;
          m_sel[k]   = w - 1;
        end
      end
    end else begin
      req = (own == 1) ? breq1 : breq2;
      if (ssplit) begin
        m_parked[k] = own;
        m_ptime[k]  = edge_cnt;
        m_owner[k]  = 0;
        m_res[k]    = 1'b0;
      end else if (!req) begin
        m_owner[k] = 0;
        m_res[k]   = 1'b0;
      end
    end
  endtask

  function automatic exp_t expv(input int k);
    exp_t e;
    e.g1 = (m_owner[k] == 1);
    e.g2 = (m_owner[k] == 2);
    e.ms = (m_sel[k] == 1);
    e.sg = m_res[k];
    e.se = m_err[k];
    return e;
  endfunction

  task automatic cyc(input logic b1, input logic b2, input logic ss, input logic sr);
    @(negedge clk);
    breq1  = b1;
    breq2  = b2;
    ssplit = ss;
    sready = sr;
    @(posedge clk);
    edge_cnt++;
    model_step(0);
    model_step(1);
    q0.push_back(expv(0));
    q1.push_back(expv(1));
  endtask

  task automatic do_reset();
    #3;
    rstn = 1'b0;
    #1;
    chk("async_rst_d0", 8'({g1[0], g2[0], ms[0], sg[0], se[0]}), 8'h00);
    chk("async_rst_d1", 8'({g1[1], g2[1], ms[1], sg[1], se[1]}), 8'h00);
    model_reset();
    breq1 = 1'b0; breq2 = 1'b0; ssplit = 1'b0; sready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  // Monitor: one comparison per instance per cycle with a queued expectation.
  always @(posedge clk) begin
    exp_t e, a;
    #1;
    if (q0.size() > 0) begin
      e = q0.pop_front();
      a = {g1[0], g2[0], ms[0], sg[0], se[0]};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL sb_dut0: got g1g2 msel sg err=%b expected %b at %0t", a, e, $time);
      end
    end
    if (q1.size() > 0) begin
      e = q1.pop_front();
      a = {g1[1], g2[1], ms[1], sg[1], se[1]};
      total++;
      if (a !== e) begin
        bad++;
        $display("FAIL sb_dut1: got g1g2 msel sg err=%b expected %b at %0t", a, e, $time);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    logic nb1, nb2, nss, nsr;
    int w;
    p_rr[0] = 0; p_to[0] = TO0;
    p_rr[1] = 1; p_to[1] = TO1;
    rstn = 1'b0;
    breq1 = 1'b0; breq2 = 1'b0; ssplit = 1'b0; sready = 1'b0;
    model_reset();
    #2;
    chk("reset_d0", 8'({g1[0], g2[0], ms[0], sg[0], se[0]}), 8'h00);
    chk("reset_d1", 8'({g1[1], g2[1], ms[1], sg[1], se[1]}), 8'h00);
    @(negedge clk);
    rstn = 1'b1;

    // Fixed priority and hand-over after release.
    cyc(1, 1, 0, 0); #2;
    chk("A_g1_d0", 8'(g1[0]), 8'd1);
    chk("A_msel_d0", 8'(ms[0]), 8'd0);
    chk("A_g1_d1", 8'(g1[1]), 8'd1);
    cyc(1, 1, 0, 0);
    cyc(0, 1, 0, 0); #2;
    chk("A_release", 8'({g1[0], g2[0]}), 8'd0);
    cyc(0, 1, 0, 0); #2;
    chk("A_g2_d0", 8'(g2[0]), 8'd1);
    chk("A_msel1_d0", 8'(ms[0]), 8'd1);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Round-robin alternation on dut1, 4-cycle transactions.
    for (int t = 0; t < 4; t++) begin
      w = (t % 2 == 0) ? 1 : 2;
      cyc(1, 1, 0, 0); #2;
      chk("B_rr_winner", 8'({g2[1], g1[1]}), (w == 1) ? 8'd1 : 8'd2);
      repeat (3) cyc(1, 1, 0, 0);
      cyc((w == 1) ? 1'b0 : 1'b1, (w == 1) ? 1'b1 : 1'b0, 0, 0); #2;
      chk("B_idle_gap", 8'({g2[1], g1[1]}), 8'd0);
    end
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Split of M1, M2 takes the bus, M1 held off.
    cyc(1, 1, 0, 0); #2;
    chk("C_g1", 8'(g1[0]), 8'd1);
    cyc(1, 1, 1, 0); #2;
    chk("C_split_drop", 8'({g1[0], g2[0]}), 8'd0);
    cyc(1, 1, 0, 0); #2;
    chk("C_other_gnt", 8'({g1[0], g2[0]}), 8'b01);
    cyc(1, 1, 0, 0);
    cyc(1, 1, 0, 0); #2;
    chk("C_parked_blocked", 8'(g1[0]), 8'd0);

    // Resumption beats a competing request.
    cyc(1, 0, 0, 0); #2;
    chk("D_idle", 8'({g1[0], g2[0]}), 8'd0);
    cyc(1, 1, 0, 1); #2;
    chk("D_resume_g1", 8'(g1[0]), 8'd1);
    chk("D_resume_sg", 8'(sg[0]), 8'd1);
    cyc(1, 1, 0, 0); #2;
    chk("D_sg_hold", 8'(sg[0]), 8'd1);
    cyc(0, 1, 0, 0); #2;
    chk("D_sg_clear", 8'({g1[0], sg[0]}), 8'd0);
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    // Timeout after TO0 pending cycles, then M1 eligible again.
    cyc(1, 0, 0, 0);
    cyc(1, 0, 1, 0);
    for (int k = 1; k <= TO0; k++) begin
      cyc(1, 0, 0, 0); #2;
      chk("E_split_err", 8'(se[0]), (k == TO0) ? 8'd1 : 8'd0);
    end
    cyc(1, 0, 0, 0); #2;
    chk("E_regrant_g1", 8'(g1[0]), 8'd1);
    chk("E_err_pulse", 8'(se[0]), 8'd0);

    // Reset mid-grant with a split pending discards the split.
    cyc(1, 0, 1, 0);
    cyc(0, 1, 0, 0);
    do_reset();
    cyc(0, 0, 0, 1); #2;
    chk("F_no_resume_d0", 8'({g1[0], g2[0], sg[0]}), 8'd0);
    chk("F_no_resume_d1", 8'({g1[1], g2[1], sg[1]}), 8'd0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      nb1 = ($urandom_range(0, 5) == 0) ? ~breq1 : breq1;
      nb2 = ($urandom_range(0, 5) == 0) ? ~breq2 : breq2;
      nss = ($urandom_range(0, 7) == 0);
      nsr = ($urandom_range(0, 5) == 0);
      cyc(nb1, nb2, nss, nsr);
      if (i % 1000 == 999) do_reset();
    end

    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/bus_split_arbiter.md
# bus_split_arbiter

Two-master arbiter for the serial system bus: grants bus ownership to one master at a time and drives the master-select for the bus muxes. Tracks one outstanding split transaction. When the split-capable slave asserts `ssplit`, the owner is parked and the bus is freed for the other master. When the slave raises `sready` again, the bus is handed back to the parked master with `split_grant` asserted to the slave. Sits between the masters' request/grant lines and the slave-side `split_grant`/`ssplit`/`sready` pins.

## Interface
- `RR_EN`, default 0: 0 = fixed priority (M1 wins), 1 = round-robin between M1/M2.
- `SPLIT_TIMEOUT`, default 255: max cycles a split may stay pending; 0 disables timeout.
- `clk`  in  1  bus clock; all state updates on rising edge.
- `rstn`  in  1  reset, asynchronous, active-low.
- `breq1`  in  1  master 1 bus request (level, held for whole transaction).
- `breq2`  in  1  master 2 bus request.
- `ssplit`  in  1  split slave signals split of the current transaction (level).
- `sready`  in  1  split slave ready to resume.
- `bgrant1`  out  1  master 1 owns bus.
- `bgrant2`  out  1  master 2 owns bus.
- `msel`  out  1  bus mux select: 0 = M1, 1 = M2; holds last value when idle.
- `split_grant`  out  1  to slave: current grant is a split resumption.
- `split_err`  out  1  one-cycle pulse: pending split abandoned on timeout.

## Operation
- States: IDLE, GNT1, GNT2. Extra registers:
  - `split_pend`: 1 bit.
  - `split_mst`: 1 bit, 0 = M1, 1 = M2.
  - `rr_last`: 1 bit.
  - timeout counter: width $clog2(SPLIT_TIMEOUT+1).
- IDLE, evaluated in this order:
  1. If `split_pend` && `sready`: enter GNT of `split_mst`, set `split_grant`, clear `split_pend`.
  2. Else arbitrate among eligible requests. A request is not eligible if `split_pend` and it comes from `split_mst`.
  3. When both are eligible: with RR_EN=0, M1 wins; with RR_EN=1, the master other than `rr_last` wins.
  4. No eligible request: stay in IDLE.
- GNTx:
  - `ssplit`=1: go to IDLE, set `split_pend`=1 and `split_mst`=x, clear `split_grant`.
  - Else `breqx`=0: go to IDLE, clear `split_grant`.
  - Else hold.
- `ssplit` is ignored in IDLE. `ssplit` during a resumed grant (`split_grant`=1) is a new split and is accepted.
- `rr_last` updates to x on every entry into GNTx, resumptions included.
- Timeout:
  - The counter resets to 0 whenever `split_pend` is set, and increments each cycle while `split_pend`=1.
  - When the counter reaches SPLIT_TIMEOUT-1 with no reclaim that cycle, clear `split_pend` and pulse `split_err` for 1 cycle.
  - The parked master becomes eligible from the next cycle.
- Simultaneous events:
  - `ssplit` and `breqx` deassertion in the same cycle: split wins.
  - Reclaim and a new request in the same cycle: reclaim wins.
  - Reclaim and timeout in the same cycle: reclaim wins, no `split_err`.

## Timing
- All outputs are registered and decoded from the state register; there is no combinational path from inputs to outputs.
- Reset (`rstn`=0): IDLE; `split_pend`=0; `rr_last`=1 (first RR contest goes to M1); counter 0. All outputs 0: `bgrant1`, `bgrant2`, `msel`, `split_grant`, `split_err`. Asserting reset mid-transaction drops grants immediately and discards the pending split.
- Grant latency: request sampled high at edge N in IDLE → `bgrantx`/`msel` valid after edge N.
- Release: `breqx` low at edge N → grant low after edge N, so the bus is idle ≥1 cycle between owners. Next grant is possible after edge N+1.
- Split: `ssplit` high at edge N → grant low after edge N.
- Resume: `sready` high at edge M in IDLE with `split_pend` → `bgrantx` and `split_grant` high after edge M.
- `bgrant1` & `bgrant2` are never both 1. `split_grant`=1 implies exactly one grant is high.

## Test plan
- Reset, then `breq1`=`breq2`=1 with RR_EN=0 → `bgrant1`=1, `msel`=0 one cycle later. Drop `breq1` → M2 granted 2 cycles after the drop, `msel`=1.
- RR_EN=1, both masters requesting continuously, each transaction 4 cycles → grants alternate M1, M2, M1, M2 with 1 idle cycle between.
- M1 granted, `ssplit` pulse → `bgrant1` falls next cycle, and M2 (requesting) is granted the following cycle. M1's held request is not granted while the split is pending.
- Split pending from M1 and the bus idle, `sready`=1 while `breq2`=1 → `bgrant1`=1, `split_grant`=1. `split_grant` clears when `breq1` drops.
- SPLIT_TIMEOUT=8, M1 split, `sready` held 0 → `split_err` pulses after 8 pending cycles; M1 granted on the next idle.
- Assert `rstn`=0 mid-grant with a split pending → all outputs 0 asynchronously. After release, `sready`=1 alone produces no grant.
